// File: rtl/lvds_out_pattern.sv
// lvds_out_pattern: framed serial pattern source for the four LVDS test lines.
// Optional PRBS-7 underrun fill when LVDS_OUT_PRBS_EN is defined.
module lvds_out_pattern #(
  parameter int DIV = 100,
  parameter int FRAME_BITS = 8,
  parameter logic [FRAME_BITS-1:0] IDLE_WORD = 'hA5
) (
  input  logic                  clk_100Mz,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [3:0]            chan_en,
  input  logic [FRAME_BITS-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  clk_out_out,
  output logic                  izp_uva_out,
  output logic                  im_uva_out,
  output logic                  do_1_out,
  output logic [2:0]            cnt_check_channel,
  output logic                  busy,
  output logic [7:0]            underrun_cnt
);

  localparam int CW = $clog2(DIV);
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt_div, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [FRAME_BITS-1:0] fill_word;
  logic bit_tick, frame_end, load, active_n;

  assign bit_tick = (cnt_div == DIV_M1);
  assign frame_end = bit_tick & (bit_idx == LAST_BIT);
  assign load = ((state == S_IDLE) & start & ~stop)
              | ((state == S_RUN) & frame_end);
  assign data_ready = load & ~rst;
  assign busy = (state != S_IDLE);
  assign active_n = (state_n != S_IDLE);

`ifdef LVDS_OUT_PRBS_EN
  logic [6:0] lfsr, lfsr_n;
  logic fb;

  // Next FRAME_BITS PRBS-7 bits, first generated bit becomes the MSB.
  always_comb begin
    lfsr_n = lfsr;
    fill_word = '0;
    fb = 1'b0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      fb = lfsr_n[6] ^ lfsr_n[5];
      fill_word = {fill_word[FRAME_BITS-2:0], fb};
      lfsr_n = {lfsr_n[5:0], fb};
    end
  end

  // LFSR steps only when a fill frame is actually loaded.
  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      lfsr <= 7'h7F;
    end else if (load && !data_valid) begin
      lfsr <= lfsr_n;
    end
  end
`else
  assign fill_word = IDLE_WORD;
`endif

  // Next-state selection for the transmit sequencer.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start && !stop) state_n = S_RUN;
      S_RUN:   if (stop) state_n = S_DRAIN;
      S_DRAIN: if (frame_end) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next bit-timing counters and shift register contents.
  always_comb begin
    cnt_n = '0;
    bit_n = '0;
    shreg_n = shreg;
    if (load) begin
      shreg_n = data_valid ? data_in : fill_word;
    end else if (active_n) begin
      cnt_n = bit_tick ? '0 : cnt_div + CW'(1);
      if (!bit_tick) begin
        bit_n = bit_idx;
      end else if (bit_idx != LAST_BIT) begin
        bit_n = bit_idx + BW'(1);
      end
      if (bit_tick) shreg_n = shreg << 1;
    end
  end

  // State, counters and shift register.
  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt_div <= '0;
      bit_idx <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt_div <= cnt_n;
      bit_idx <= bit_n;
      shreg <= shreg_n;
    end
  end

  // Registered, masked line outputs derived from next-cycle timing.
  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      clk_out_out <= 1'b0;
      izp_uva_out <= 1'b0;
      im_uva_out <= 1'b0;
      do_1_out <= 1'b0;
    end else begin
      clk_out_out <= active_n & chan_en[0] & (cnt_n >= HALF);
      izp_uva_out <= active_n & chan_en[1] & (bit_n == '0);
      im_uva_out <= active_n & chan_en[2] & (bit_n == LAST_BIT);
      do_1_out <= active_n & chan_en[3] & shreg_n[FRAME_BITS-1];
    end
  end

  // Completed-frame counter and saturating fill-frame counter.
  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      cnt_check_channel <= '0;
      underrun_cnt <= '0;
    end else begin
      if (frame_end && state != S_IDLE) begin
        cnt_check_channel <= cnt_check_channel + 3'd1;
      end
      if (load && !data_valid && underrun_cnt != 8'hFF) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

endmodule
